// File: rtl/btn_debounce_pkg.sv
// Shared button-conditioning definitions: FSM state encoding and time conversion.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package btn_debounce_pkg;

    // Button FSM states; all four 2-bit codes are assigned.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL     = 2'd3
    } btn_state_t;

    // Converts a duration in milliseconds into clock cycles. The long-press block uses it too.
    function automatic int ms_to_cycles(input int clk_freq_hz, input int ms);
        return (clk_freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Generic N-flop synchroniser for asynchronous inputs, with a synchronous reset value.
// Latency: STAGES clock edges from input change to output.
// Backpressure: none, free-running.
module sync_ff #(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the input through the flop chain; reset loads the idle value into every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit a clean level plus press/release strobes.
// Latency: SYNC_STAGES + DB_CYCLES edges from the first edge that samples a clean raw change.
// Backpressure: none; strobes are single-cycle and must be consumed when they are high.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic db_busy
);

    localparam int DB_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int CNT_W     = $clog2(DB_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES);

    // Pin value when the button is released; also the synchroniser reset value.
    localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

    generate
        if (DB_CYCLES < 2) begin : g_bad_db_cycles
            $error("btn_debounce: debounce window must be at least 2 cycles");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("btn_debounce: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic       pin_sync;
    logic       s;
    btn_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic       press_nxt;
    logic       release_nxt;

    sync_ff #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (PIN_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (pin_sync)
    );

    // Normalised sample: 1 means pressed regardless of pin polarity.
    assign s = pin_sync ^ PIN_IDLE;

    // State, counter and strobe registers; reset discards any candidate without a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= CNT_ZERO;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    // Next state: any opposite sample while timing restarts from the stable state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_nxt = ST_ARM;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_ARM: begin
                if (!s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = CNT_ZERO;
                    press_nxt = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_nxt = ST_REL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_REL: begin
                if (s) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = CNT_ZERO;
                    release_nxt = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Level and busy are decoded straight from the state register.
    assign btn_level = (state == ST_PRESSED) || (state == ST_REL);
    assign db_busy   = (state == ST_ARM)     || (state == ST_REL);

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with a strobe scoreboard.
// Latency: expected strobes are timestamped at drive time and matched at negedge.
// Backpressure: n/a.
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b1;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic db_busy;

    btn_debounce #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (4),
        .ACTIVE_LOW  (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .db_busy     (db_busy)
    );

    always #5 clk = ~clk;

    // Number of posedges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit is_press;
        int at;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  checks = 0;
    int  errors = 0;

    // Scoreboard consumer: every strobe must match the oldest expected event and its cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (btn_press === 1'b1 && btn_release === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap cyc=%0d press=1 release=1, required at most one", cyc);
            end else if (btn_press === 1'b1 || btn_release === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d press=%0b release=%0b, required none",
                             cyc, btn_press, btn_release);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.is_press !== btn_press || ev.at !== cyc) begin
                        errors++;
                        $display("FAIL strobe_match got press=%0b at cyc %0d, required press=%0b at cyc %0d",
                                 btn_press, cyc, ev.is_press, ev.at);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                errors++;
                ev = exp_q.pop_front();
                $display("FAIL missed_strobe press=%0b expected at cyc %0d, still absent at cyc %0d",
                         ev.is_press, ev.at, cyc);
            end
        end
    end

    task automatic test_reset();
        rst     = 1'b1;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({btn_level, btn_press, btn_release, db_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0000",
                     {btn_level, btn_press, btn_release, db_busy});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_press, btn_release, db_busy} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d got %b required 0000", i,
                         {btn_level, btn_press, btn_release, db_busy});
            end
        end
    endtask

    task automatic test_press();
        int n0;
        n0      = cyc;
        btn_raw = 1'b0;
        exp_q.push_back('{1'b1, n0 + 6});
        repeat (5) @(negedge clk);
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL press_early level=%b required 0 at edge 5", btn_level);
        end
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b1 || btn_press !== 1'b1) begin
            errors++;
            $display("FAIL press_edge6 level=%b press=%b required 1 1", btn_level, btn_press);
        end
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b1 || btn_press !== 1'b0) begin
            errors++;
            $display("FAIL press_edge7 level=%b press=%b required 1 0", btn_level, btn_press);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_release_glitch();
        int busy_cnt;
        busy_cnt = 0;
        btn_raw  = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (i == 3) btn_raw = 1'b0;
            busy_cnt += int'(db_busy);
            checks++;
            if (btn_level !== 1'b1) begin
                errors++;
                $display("FAIL glitch_level cycle %0d level=%b required 1", i, btn_level);
            end
        end
        checks++;
        if (busy_cnt != 3) begin
            errors++;
            $display("FAIL glitch_busy busy cycles=%0d required 3", busy_cnt);
        end
    endtask

    task automatic test_clean_release();
        int n0;
        n0      = cyc;
        btn_raw = 1'b1;
        exp_q.push_back('{1'b0, n0 + 6});
        repeat (5) @(negedge clk);
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL release_early level=%b required 1 at edge 5", btn_level);
        end
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b0 || btn_release !== 1'b1) begin
            errors++;
            $display("FAIL release_edge6 level=%b release=%b required 0 1", btn_level, btn_release);
        end
        @(negedge clk);
        checks++;
        if (btn_release !== 1'b0) begin
            errors++;
            $display("FAIL release_edge7 release=%b required 0", btn_release);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic [3:0] pattern;
        int         press_cnt;
        int         n0;
        pattern   = 4'b1010;
        press_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            btn_raw = pattern[i];
            @(negedge clk);
            press_cnt += int'(btn_press);
        end
        n0      = cyc;
        btn_raw = 1'b0;
        exp_q.push_back('{1'b1, n0 + 6});
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            press_cnt += int'(btn_press);
        end
        checks++;
        if (press_cnt != 1) begin
            errors++;
            $display("FAIL bounce_presses count=%0d required 1", press_cnt);
        end
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL bounce_level level=%b required 1", btn_level);
        end
    endtask

    task automatic test_reset_mid_arm();
        btn_raw = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (db_busy !== 1'b1 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL arm_busy busy=%b level=%b required 1 0", db_busy, btn_level);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({btn_level, btn_press, db_busy} !== 3'b000) begin
            errors++;
            $display("FAIL mid_arm_reset got %b required 000", {btn_level, btn_press, db_busy});
        end
        rst = 1'b0;
        exp_q.push_back('{1'b1, cyc + 6});
        repeat (5) @(negedge clk);
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL rearm_early level=%b required 0", btn_level);
        end
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b1 || btn_press !== 1'b1) begin
            errors++;
            $display("FAIL rearm_press level=%b press=%b required 1 1", btn_level, btn_press);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_press();
        test_release_glitch();
        test_clean_release();
        test_bounce();
        test_clean_release();
        test_reset_mid_arm();
        test_clean_release();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d required bench completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
